// File: rtl/led_scan_if.sv
// Bundle between the board wrapper and the LED scan controller.
// Signals:
//   en           - scan enable, low forces blanking
//   leds1..leds4 - column 1..4 pixel data, bit i = row i+1, 1 = lit
//   leds_pwm     - brightness, 0 = dimmest, 7 = full
//   row_o        - row drive, active high
//   col_n_o      - column select, active low
//   frame_strobe - one-clock pulse when new frame data is latched
// Modports: master = pixel/enable source, slave = scan controller.
interface led_scan_if;
    logic       en;
    logic [7:0] leds1;
    logic [7:0] leds2;
    logic [7:0] leds3;
    logic [7:0] leds4;
    logic [2:0] leds_pwm;
    logic [7:0] row_o;
    logic [3:0] col_n_o;
    logic       frame_strobe;

    modport master (
        output en, leds1, leds2, leds3, leds4, leds_pwm,
        input  row_o, col_n_o, frame_strobe
    );

    modport slave (
        input  en, leds1, leds2, leds3, leds4, leds_pwm,
        output row_o, col_n_o, frame_strobe
    );
endinterface

// File: rtl/led_scan_ctrl.sv
// Time-multiplexed scan controller for the 8x4 LED matrix.
// Each column slot is BLANK_CYCLES clocks dark followed by 8*PWM_DIV clocks
// of drive with 8-step PWM. Pixel data and brightness are double-buffered
// and latched only at frame start (column wrap, reset, or en rising).
// Ports:
//   clk - system clock
//   rst - asynchronous active-high reset
//   bus - led_scan_if.slave (en, leds1..4, leds_pwm in; row_o, col_n_o,
//         frame_strobe out, all registered)
// Optional build macro LED_SCAN_GAMMA_EN: perceptual duty table instead of
// the linear duty = brightness + 1.
module led_scan_ctrl #(
    parameter int unsigned BLANK_CYCLES = 40,
    parameter int unsigned PWM_DIV      = 375
) (
    input  logic     clk,
    input  logic     rst,
    led_scan_if.slave bus
);
    localparam int unsigned TICK_MAX = (BLANK_CYCLES > PWM_DIV) ? BLANK_CYCLES : PWM_DIV;
    localparam int unsigned TW       = $clog2(TICK_MAX + 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0] PWM_LAST   = TW'(PWM_DIV - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t          state, state_nx;
    logic [1:0]      col, col_nx;
    logic [TW-1:0]   tick, tick_nx;     // blank count in BLANK, PWM sub-step in DRIVE
    logic [2:0]      step, step_nx;     // PWM step 0..7 within DRIVE
    logic            pend, pend_nx;     // a fresh latch is owed (after reset / en low)
    logic            latch;
    logic [7:0]      row_nx;
    logic [3:0]      col_n_nx;
    logic [3:0][7:0] shadow;
    logic [2:0]      shadow_pwm;
    logic [3:0]      duty;

    // Rows are lit while step < duty
`ifdef LED_SCAN_GAMMA_EN
    always_comb begin
        case (shadow_pwm)
            3'd0, 3'd1, 3'd2: duty = 4'd1;
            3'd3:             duty = 4'd2;
            3'd4:             duty = 4'd3;
            3'd5:             duty = 4'd4;
            3'd6:             duty = 4'd6;
            default:          duty = 4'd8;
        endcase
    end
`else
    assign duty = {1'b0, shadow_pwm} + 4'd1;
`endif

    // Next-state, latch request and next output values
    always_comb begin
        state_nx = state;
        col_nx   = col;
        tick_nx  = tick;
        step_nx  = step;
        pend_nx  = pend;
        latch    = 1'b0;
        row_nx   = 8'h00;
        col_n_nx = 4'hF;

        if (!bus.en) begin
            state_nx = BLANK;
            col_nx   = 2'd0;
            tick_nx  = '0;
            step_nx  = 3'd0;
            pend_nx  = 1'b1;
        end else begin
            case (state)
                BLANK: begin
                    if (pend) begin
                        // fresh frame: restart the blank period on the latch clock
                        latch   = 1'b1;
                        pend_nx = 1'b0;
                        tick_nx = '0;
                    end else if (tick == BLANK_LAST) begin
                        state_nx = DRIVE;
                        tick_nx  = '0;
                        step_nx  = 3'd0;
                    end else begin
                        tick_nx = tick + TW'(1);
                    end
                end
                DRIVE: begin
                    if (tick == PWM_LAST) begin
                        tick_nx = '0;
                        if (step == 3'd7) begin
                            state_nx = BLANK;
                            col_nx   = col + 2'd1;
                            latch    = (col == 2'd3);
                        end else begin
                            step_nx = step + 3'd1;
                        end
                    end else begin
                        tick_nx = tick + TW'(1);
                    end
                end
                default: state_nx = BLANK;
            endcase
        end

        if (state_nx == DRIVE) begin
            col_n_nx = ~(4'b0001 << col_nx);
            if ({1'b0, step_nx} < duty)
                row_nx = shadow[col_nx];
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= BLANK;
            col              <= 2'd0;
            tick             <= '0;
            step             <= 3'd0;
            pend             <= 1'b1;
            bus.row_o        <= 8'h00;
            bus.col_n_o      <= 4'hF;
            bus.frame_strobe <= 1'b0;
        end else begin
            state            <= state_nx;
            col              <= col_nx;
            tick             <= tick_nx;
            step             <= step_nx;
            pend             <= pend_nx;
            bus.row_o        <= row_nx;
            bus.col_n_o      <= col_n_nx;
            bus.frame_strobe <= latch;
        end
    end

    // Frame buffer, updated only at frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            shadow_pwm <= 3'd0;
        end else if (latch) begin
            shadow     <= {bus.leds4, bus.leds3, bus.leds2, bus.leds1};
            shadow_pwm <= bus.leds_pwm;
        end
    end
endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl with BLANK_CYCLES=2, PWM_DIV=1.
// Reference model tracks the position inside the frame and derives the
// expected row/column/strobe arithmetically from it.
module tb_led_scan_ctrl;
    localparam int unsigned BLANK = 2;
    localparam int unsigned PDIV  = 1;
    localparam int unsigned SLOT  = BLANK + 8 * PDIV;
    localparam int unsigned FRAME = 4 * SLOT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_scan_if bus ();

    led_scan_ctrl #(.BLANK_CYCLES(BLANK), .PWM_DIV(PDIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0] m_frame [4];
    logic [2:0] m_pwm;
    bit         m_active;
    int         m_p;
    logic [7:0] e_row;
    logic [3:0] e_col;
    logic       e_stb;

    function automatic int duty_of(input logic [2:0] b);
`ifdef LED_SCAN_GAMMA_EN
        case (b)
            3'd0, 3'd1, 3'd2: return 1;
            3'd3: return 2;
            3'd4: return 3;
            3'd5: return 4;
            3'd6: return 6;
            default: return 8;
        endcase
`else
        return int'(b) + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_p      = 0;
        for (int i = 0; i < 4; i++) m_frame[i] = 8'h00;
        m_pwm = 3'd0;
        e_row = 8'h00;
        e_col = 4'hF;
        e_stb = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present now
    task automatic model_edge();
        int slot, w, stp;
        e_row = 8'h00;
        e_col = 4'hF;
        e_stb = 1'b0;
        if (!bus.en) begin
            m_active = 1'b0;
        end else begin
            if (!m_active) begin
                m_active = 1'b1;
                m_p      = 0;
            end else begin
                m_p = (m_p + 1) % FRAME;
            end
            if (m_p == 0) begin
                m_frame[0] = bus.leds1;
                m_frame[1] = bus.leds2;
                m_frame[2] = bus.leds3;
                m_frame[3] = bus.leds4;
                m_pwm      = bus.leds_pwm;
                e_stb      = 1'b1;
            end
            slot = m_p / SLOT;
            w    = m_p % SLOT;
            if (w >= BLANK) begin
                stp   = (w - BLANK) / PDIV;
                e_col = 4'hF & ~(4'b0001 << slot);
                if (stp < duty_of(m_pwm)) e_row = m_frame[slot];
            end
        end
    endtask

    // One clock: predict, clock, then compare #1 after the edge
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("row", bus.row_o, e_row);
        chk("col", 8'(bus.col_n_o), 8'(e_col));
        chk("strobe", 8'(bus.frame_strobe), 8'(e_stb));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_col(input logic [3:0] c, input string tag);
        int n = 0;
        while (bus.col_n_o !== c && n < 200) begin
            cyc();
            n++;
        end
        total++;
        assert (n < 200) else begin
            bad++;
            $error("FAIL %s timeout waiting col_n_o=%b observed=%b", tag, c, bus.col_n_o);
        end
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (bus.frame_strobe !== 1'b1 && n < 200);
        total++;
        assert (n < 200) else begin
            bad++;
            $error("FAIL %s timeout waiting frame_strobe observed=%b expected=1", tag, bus.frame_strobe);
        end
    endtask

    initial begin
        int lit;
        int gap;
        rst = 1'b1;
        bus.en = 1'b1;
        bus.leds1 = 8'hA5;
        bus.leds2 = 8'h00;
        bus.leds3 = 8'h00;
        bus.leds4 = 8'h00;
        bus.leds_pwm = 3'd7;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row", bus.row_o, 8'h00);
        chk("rst_col", 8'(bus.col_n_o), 8'h0F);
        chk("rst_strobe", 8'(bus.frame_strobe), 8'h00);
        rst = 1'b0;

        // first frame after reset: strobe, 2 blank, column 0 shows A5
        cyc();
        chk("first_strobe", 8'(bus.frame_strobe), 8'h01);
        run(2);
        chk("first_col0", 8'(bus.col_n_o), 8'h0E);
        chk("first_row0", bus.row_o, 8'hA5);
        run(FRAME * 2);

        // one lit row per column
        bus.leds1 = 8'h01;
        bus.leds2 = 8'h02;
        bus.leds3 = 8'h04;
        bus.leds4 = 8'h08;
        wait_strobe("walk_latch");
        run(FRAME * 2);

        // brightness 2: count lit cycles over one full frame
        bus.leds1 = 8'hFF;
        bus.leds2 = 8'hFF;
        bus.leds3 = 8'hFF;
        bus.leds4 = 8'hFF;
        bus.leds_pwm = 3'd2;
        wait_strobe("pwm_latch");
        lit = (bus.row_o != 8'h00) ? 1 : 0;
        for (int i = 1; i < FRAME; i++) begin
            cyc();
            if (bus.row_o != 8'h00) lit++;
        end
        chk("pwm2_lit", 8'(lit), 8'(4 * duty_of(3'd2)));
        bus.leds_pwm = 3'd5;
        wait_strobe("pwm5_latch");
        run(FRAME);
        bus.leds_pwm = 3'd0;
        wait_strobe("pwm0_latch");
        run(FRAME);

        // double buffer: leds2 change during column 0 is invisible until next frame
        bus.leds_pwm = 3'd7;
        bus.leds2 = 8'hFF;
        wait_strobe("dbuf_latch");
        run(3);
        bus.leds2 = 8'h00;
        wait_col(4'b1101, "dbuf_col1");
        chk("dbuf_old", bus.row_o, 8'hFF);
        wait_strobe("dbuf_next");
        wait_col(4'b1101, "dbuf_col1b");
        chk("dbuf_new", bus.row_o, 8'h00);

        // en low mid column 2, then restart
        wait_col(4'b1011, "en_col2");
        run(2);
        bus.en = 1'b0;
        cyc();
        chk("en_off_row", bus.row_o, 8'h00);
        chk("en_off_col", 8'(bus.col_n_o), 8'h0F);
        run(6);
        bus.en = 1'b1;
        cyc();
        chk("en_restart_strobe", 8'(bus.frame_strobe), 8'h01);
        run(2);
        chk("en_restart_col0", 8'(bus.col_n_o), 8'h0E);
        run(FRAME);

        // asynchronous reset mid-DRIVE
        wait_col(4'b1011, "rst_col2");
        run(1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_row", bus.row_o, 8'h00);
        chk("arst_col", 8'(bus.col_n_o), 8'h0F);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_hold_col", 8'(bus.col_n_o), 8'h0F);
        rst = 1'b0;
        cyc();
        chk("arst_strobe", 8'(bus.frame_strobe), 8'h01);
        run(2);
        chk("arst_col0", 8'(bus.col_n_o), 8'h0E);
        run(FRAME);

        // randomized inputs, brightness and enable drops
        gap = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(1, 4))
                    1: bus.leds1 = 8'($urandom);
                    2: bus.leds2 = 8'($urandom);
                    3: bus.leds3 = 8'($urandom);
                    default: bus.leds4 = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 39) == 0) bus.leds_pwm = 3'($urandom);
            if (gap > 0) begin
                gap--;
                if (gap == 0) bus.en = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                bus.en = 1'b0;
                gap = int'($urandom_range(1, 5));
            end
            cyc();
        end
        bus.en = 1'b1;
        run(FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-row x 4-column LED matrix on the iCEFUN board.
- Sequences column strobes and row drive, and inserts blanking between columns to prevent ghosting.
- Applies 8-step PWM brightness and double-buffers frame data so pixel content only changes at frame boundaries.
- Sits between the SoC/debug LED signals and the board LED pins, in the top-level board wrapper.

Parameters:
- BLANK_CYCLES, 40, clocks per column slot with all LEDs off (minimum 1)
- PWM_DIV, 375, clocks per PWM step (minimum 1); the drive phase lasts 8*PWM_DIV clocks
- Derived: SLOT = BLANK_CYCLES + 8*PWM_DIV clocks; FRAME = 4*SLOT clocks

Ports:
- clk  in  1  system clock (12 MHz on iCEFUN)
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable; low forces blanking
- leds1  in  8  column 1 pixel data, bit i = row i+1, 1 = lit
- leds2  in  8  column 2 pixel data
- leds3  in  8  column 3 pixel data
- leds4  in  8  column 4 pixel data
- leds_pwm  in  3  brightness, 0 = dimmest, 7 = full
- row_o  out  8  row drive, active high
- col_n_o  out  4  column select, active low, one-hot-low or all high
- frame_strobe  out  1  one-clock pulse when new frame data is latched

Behaviour:
- One clock domain. Reset is asynchronous and active-high (rst), with synchronous deassertion assumed at board level.
- All outputs are registered. Reset values:
  - row_o = 8'h00
  - col_n_o = 4'hF
  - frame_strobe = 0
  - state = BLANK, col = 0, tick = 0
  - shadow frame buffer = 0, shadow brightness = 0
- State machine:
  - BLANK: row_o = 0, col_n_o = 4'hF. Stays for BLANK_CYCLES clocks, then goes to DRIVE with tick = 0.
  - DRIVE: col_n_o bit[col] = 0, other bits = 1.
    - step = tick / PWM_DIV, range 0..7.
    - row_o = shadow[col] when step < duty, otherwise 8'h00.
    - After 8*PWM_DIV clocks, goes to BLANK and col = col + 1 mod 4.
- Frame latch:
  - On the BLANK entry where col wraps from 3 to 0, and also on the first BLANK after reset or after en rises:
    - shadow[0..3] <= leds1..leds4
    - shadow brightness <= leds_pwm
    - frame_strobe = 1 for exactly that clock
  - Input changes mid-frame have no visible effect until the next latch.
- Duty (without the optional feature): duty = shadow_pwm + 1, range 1..8. Value 7 means rows are driven for the whole DRIVE phase.
- Row and column transitions:
  - Row and column never change in the same clock that both select a lit LED.
  - Exiting DRIVE, row_o and col_n_o go off on the same edge.
  - Entering DRIVE, col_n_o asserts first; row_o follows the duty rule from tick 0.
- en low, synchronously sampled:
  - Next clock: row_o = 0, col_n_o = 4'hF, state = BLANK, col = 0, tick = 0.
  - Counters are held.
  - frame_strobe = 0 while en is low.
- en rising: scanning restarts at column 0 with a fresh latch.
- Reset mid-slot: outputs return to reset values immediately (asynchronous).
- Counter widths are sized from the parameters, e.g. $clog2(8*PWM_DIV). No counter wraps except col.

Optional Feature:
- Macro: LED_SCAN_GAMMA_EN
- Defined: duty comes from a perceptual table indexed by shadow brightness: 0..7 -> 1,1,1,2,3,4,6,8.
- Undefined: duty = shadow_pwm + 1 (linear). The table logic is absent.

Test Plan (BLANK_CYCLES=2, PWM_DIV=1, so SLOT = 10 clocks and FRAME = 40 clocks):
- Reset, then release with en=1, leds1=8'hA5, leds_pwm=7:
  - frame_strobe pulses on the first BLANK clock.
  - After 2 blank clocks: col_n_o = 4'b1110 and row_o = 8'hA5 for 8 clocks.
  - Then 2 blank clocks with row_o = 0 and col_n_o = 4'hF.
- leds1..leds4 = 01,02,04,08 with pwm=7:
  - col_n_o sequences 1110, 1101, 1011, 0111 with row_o 01, 02, 04, 08.
  - frame_strobe pulses every 40 clocks.
- leds_pwm=2, linear: in each DRIVE phase, row_o is non-zero for exactly 3 clocks, then 0 for 5 clocks.
- LED_SCAN_GAMMA_EN defined:
  - leds_pwm=5 gives rows on for 4 of 8 clocks.
  - leds_pwm=0 gives 1 of 8.
- Change leds2 from 8'hFF to 8'h00 during column 0 of a frame: column 1 still shows 8'hFF; 8'h00 appears only after the next frame_strobe.
- Deassert en mid-DRIVE of column 2:
  - Next clock row_o = 0, col_n_o = 4'hF, no strobes.
  - Reassert en: strobe, 2 blank clocks, then column 0 drives.
  - Repeat the same check with rst asserted asynchronously mid-DRIVE.
